// File: rtl/xixq_pkg.sv
// Shared constants, types and default frame ROM for the xixq_cal Alamouti pre-combiner.
// Samples are signed Q4.11, so 1.0 = 0x0800.
package xixq_pkg;

    localparam int DW              = 16;
    localparam int FRAC            = 11;
    localparam int NUM_FRAMES      = 4;
    localparam int WORDS_PER_FRAME = 8;
    localparam int ACC_W           = 2 * DW + 2;
    localparam int FRAME_W         = $clog2(NUM_FRAMES);
    localparam int ADDR_W          = FRAME_W + 3;

    localparam logic signed [DW-1:0]    SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0]    SAT_MIN = 16'sh8000;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

    typedef enum logic [2:0] {
        H1R = 3'd0, H1I = 3'd1, H2R = 3'd2, H2I = 3'd3,
        Y1R = 3'd4, Y1I = 3'd5, Y2R = 3'd6, Y2I = 3'd7
    } word_idx_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } state_e;

    // Word order per frame: h1r h1i h2r h2i y1r y1i y2r y2i
    localparam logic [DW-1:0] ROM_INIT [0:NUM_FRAMES*WORDS_PER_FRAME-1] = '{
        16'h0800, 16'h0000, 16'h0400, 16'h0400, 16'h0800, 16'h0800, 16'hF800, 16'h0000,
        16'h3FFF, 16'h3FFF, 16'h0000, 16'h0000, 16'h3FFF, 16'h3FFF, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0800, 16'h0000, 16'h0400, 16'h0400, 16'hF800, 16'hF800, 16'h0800, 16'h0000
    };

endpackage

// File: rtl/xixq_cmac.sv
// Combinational four-term signed product sum with per-term sign control,
// followed by an arithmetic shift by FRAC and saturation to DW bits.
module xixq_cmac
    import xixq_pkg::*;
(
    input  logic [4*DW-1:0] a_i,
    input  logic [4*DW-1:0] b_i,
    input  logic [3:0]      neg_i,
    output logic [DW-1:0]   sum_o
);

    logic signed [2*DW-1:0]  prod_s;
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] shift_s;

    // Accumulate the signed products, then rescale and clamp
    always_comb begin
        prod_s = '0;
        acc_s  = '0;
        for (int t = 0; t < 4; t++) begin
            prod_s = $signed(a_i[t*DW +: DW]) * $signed(b_i[t*DW +: DW]);
            if (neg_i[t]) begin
                acc_s = acc_s - ACC_W'(prod_s);
            end else begin
                acc_s = acc_s + ACC_W'(prod_s);
            end
        end
        shift_s = acc_s >>> FRAC;
        if (shift_s > ACC_MAX) begin
            sum_o = SAT_MAX;
        end else if (shift_s < ACC_MIN) begin
            sum_o = SAT_MIN;
        end else begin
            sum_o = shift_s[DW-1:0];
        end
    end

endmodule

// File: rtl/xixq_cal.sv
// Alamouti/SOML pre-combiner: walks the frame ROM, loads eight operand words
// per frame and registers s1 = h1*.y1 + h2.y2*, s2 = h2*.y1 - h1.y2*.
module xixq_cal
    import xixq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [DW-1:0] out_xI1,
    output logic [DW-1:0] out_xQ1,
    output logic [DW-1:0] out_xI2,
    output logic [DW-1:0] out_xQ2
);

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [2:0]         K_LAST     = 3'd7;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [2:0]           k_q, k_d;
    logic [DW-1:0]        op_q [WORDS_PER_FRAME];
    logic                 load_en_s, calc_en_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [DW-1:0]        rom_word_s;
    logic [DW-1:0]        re1_s, im1_s, re2_s, im2_s;

    assign addr_s     = {frame_q, k_q};
    assign rom_word_s = ROM_INIT[addr_s];

    // Next-state, counter and enable logic
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        k_d       = k_q;
        load_en_s = 1'b0;
        calc_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    frame_d = '0;
                    k_d     = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                load_en_s = 1'b1;
                k_d       = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    state_d = CALC;
                end else begin
                    state_d = LOAD;
                end
            end
            CALC: begin
                calc_en_s = 1'b1;
                k_d       = 3'd0;
                if (frame_q < LAST_FRAME) begin
                    frame_d = frame_q + FRAME_W'(1);
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, operand and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            k_q     <= 3'd0;
            for (int i = 0; i < WORDS_PER_FRAME; i++) begin
                op_q[i] <= '0;
            end
            out_xI1 <= '0;
            out_xQ1 <= '0;
            out_xI2 <= '0;
            out_xQ2 <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            k_q     <= k_d;
            if (load_en_s) begin
                op_q[k_q] <= rom_word_s;
            end
            if (calc_en_s) begin
                out_xI1 <= re1_s;
                out_xQ1 <= im1_s;
                out_xI2 <= re2_s;
                out_xQ2 <= im2_s;
            end
        end
    end

    // Terms are packed {t3, t2, t1, t0}; neg bit t subtracts term t
    xixq_cmac u_re1 (
        .a_i   ({op_q[H2I], op_q[H2R], op_q[H1I], op_q[H1R]}),
        .b_i   ({op_q[Y2I], op_q[Y2R], op_q[Y1I], op_q[Y1R]}),
        .neg_i (4'b0000),
        .sum_o (re1_s)
    );

    xixq_cmac u_im1 (
        .a_i   ({op_q[H2R], op_q[H2I], op_q[H1I], op_q[H1R]}),
        .b_i   ({op_q[Y2I], op_q[Y2R], op_q[Y1R], op_q[Y1I]}),
        .neg_i (4'b1010),
        .sum_o (im1_s)
    );

    xixq_cmac u_re2 (
        .a_i   ({op_q[H1I], op_q[H1R], op_q[H2I], op_q[H2R]}),
        .b_i   ({op_q[Y2I], op_q[Y2R], op_q[Y1I], op_q[Y1R]}),
        .neg_i (4'b1100),
        .sum_o (re2_s)
    );

    xixq_cmac u_im2 (
        .a_i   ({op_q[H1R], op_q[H1I], op_q[H2I], op_q[H2R]}),
        .b_i   ({op_q[Y2I], op_q[Y2R], op_q[Y1R], op_q[Y1I]}),
        .neg_i (4'b0110),
        .sum_o (im2_s)
    );

endmodule

// File: tb/tb_xixq_cal.sv
// Self-checking bench for xixq_cal: complex-arithmetic reference model over
// the frame table, checked every cycle against randomized start/reset timing.
module tb_xixq_cal;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] out_xI1, out_xQ1, out_xI2, out_xQ2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q;
    wire  [63:0] obs = {out_xI1, out_xQ1, out_xI2, out_xQ2};

    logic [15:0] rom [0:31] = '{
        16'h0800, 16'h0000, 16'h0400, 16'h0400, 16'h0800, 16'h0800, 16'hF800, 16'h0000,
        16'h3FFF, 16'h3FFF, 16'h0000, 16'h0000, 16'h3FFF, 16'h3FFF, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0800, 16'h0000, 16'h0400, 16'h0400, 16'hF800, 16'hF800, 16'h0800, 16'h0000
    };

    xixq_cal dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .out_xI1 (out_xI1),
        .out_xQ1 (out_xQ1),
        .out_xI2 (out_xI2),
        .out_xQ2 (out_xQ2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input longint v);
        longint s;
        s = v >>> 11;
        if (s > 32767)       return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else                 return s[15:0];
    endfunction

    // Complex arithmetic on frame f: s1 = conj(h1)y1 + h2 conj(y2), s2 = conj(h2)y1 - h1 conj(y2)
    function automatic logic [63:0] model(input int f);
        longint h1r, h1i, h2r, h2i, y1r, y1i, y2r, y2i;
        longint re1, im1, re2, im2;
        h1r = longint'($signed(rom[f*8+0])); h1i = longint'($signed(rom[f*8+1]));
        h2r = longint'($signed(rom[f*8+2])); h2i = longint'($signed(rom[f*8+3]));
        y1r = longint'($signed(rom[f*8+4])); y1i = longint'($signed(rom[f*8+5]));
        y2r = longint'($signed(rom[f*8+6])); y2i = longint'($signed(rom[f*8+7]));
        // conj(h1)*y1 = (h1r y1r + h1i y1i) + j(h1r y1i - h1i y1r); h2*conj(y2) = (h2r y2r + h2i y2i) + j(h2i y2r - h2r y2i)
        re1 = (h1r*y1r + h1i*y1i) + (h2r*y2r + h2i*y2i);
        im1 = (h1r*y1i - h1i*y1r) + (h2i*y2r - h2r*y2i);
        // conj(h2)*y1 - h1*conj(y2)
        re2 = (h2r*y1r + h2i*y1i) - (h1r*y2r + h1i*y2i);
        im2 = (h2r*y1i - h2i*y1r) - (h1i*y2r - h1r*y2i);
        return {sat16(re1), sat16(im1), sat16(re2), sat16(im2)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        exp_q = 64'h0;
        tests_run++;
        if (obs !== exp_q) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h", obs, exp_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_q) begin
                tests_failed++;
                $display("FAIL idle_after_reset cyc %0d: got %h expected %h", i, obs, exp_q);
            end
        end
    endtask

    task automatic idle_hold(input int n, input string name);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_q) begin
                tests_failed++;
                $display("FAIL %s hold cyc %0d: got %h expected %h", name, i, obs, exp_q);
            end
        end
    endtask

    // Edge E is cyc 0; start stays high for `hold` edges; optional reset at edge E+rst_at
    task automatic run_sequence(input int hold, input int rst_at, input string name);
        for (int cyc = 0; cyc <= 36; cyc++) begin
            start = (cyc < hold);
            rst   = (cyc == rst_at);
            tick();
            if (cyc == rst_at) begin
                exp_q = 64'h0;
            end else if (cyc > 0 && (cyc % 9) == 0) begin
                exp_q = model(cyc / 9 - 1);
            end
            tests_run++;
            if (obs !== exp_q) begin
                tests_failed++;
                $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, obs, exp_q);
            end
            if (cyc == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_first_pass();
        run_sequence(2, -1, "first_pass");
        tests_run++;
        if (obs !== 64'hFC00_FC00_F000_0000) begin
            tests_failed++;
            $display("FAIL last_frame_literal: got %h expected %h", obs, 64'hFC00_FC00_F000_0000);
        end
        idle_hold(200, "after_done");
    endtask

    task automatic test_start_during_load();
        for (int r = 0; r < 3; r++) begin
            run_sequence($urandom_range(3, 30), -1, "start_held");
            idle_hold($urandom_range(1, 10), "start_held_idle");
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            idle_hold($urandom_range(0, 5), "b2b_gap");
            run_sequence($urandom_range(1, 8), -1, "b2b");
        end
    endtask

    task automatic test_reset_midrun();
        run_sequence(1, 20, "reset_at_20");
        idle_hold($urandom_range(1, 8), "after_reset");
        run_sequence(1, -1, "after_reset_run");
        for (int r = 0; r < 4; r++) begin
            idle_hold($urandom_range(0, 4), "rand_reset_gap");
            run_sequence($urandom_range(1, 6), $urandom_range(1, 36), "rand_reset");
            idle_hold($urandom_range(1, 6), "rand_reset_idle");
            run_sequence(1, -1, "rand_reset_rerun");
        end
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_start_during_load();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xixq_cal.md
Name: xixq_cal

Overview:
- Alamouti/SOML pre-combiner for a 2-Tx STBC decoder.
- On `start`, reads NUM_FRAMES frames from an internal constant ROM, one frame after another. Each frame holds channel gains h1, h2 and received samples y1, y2, all complex.
- For each frame it computes the combined symbol estimates s1 = conj(h1)·y1 + h2·conj(y2) and s2 = conj(h2)·y1 − h1·conj(y2).
- Outputs the real/imaginary parts (xI/xQ) of s1 and s2, which feed the downstream SOML slicer.

Parameters:
- DW, 16, data word width (signed two's complement).
- FRAC, 11, fractional bits (Q4.11, so 1.0 = 0x0800).
- NUM_FRAMES, 4, number of ROM frames processed per start.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled start request; acted on only in IDLE.
- out_xI1  out  16  Re(s1), signed Q4.11.
- out_xQ1  out  16  Im(s1).
- out_xI2  out  16  Re(s2).
- out_xQ2  out  16  Im(s2).

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, frame counter 0, word counter 0, operand registers 0. `rst` has priority over everything, including mid-operation: the next edge forces this state.
- ROM: NUM_FRAMES×8 words, combinational read. Address = frame·8 + k.
- Word order within a frame: k0 h1r, k1 h1i, k2 h2r, k3 h2i, k4 y1r, k5 y1i, k6 y2r, k7 y2i.
- FSM IDLE: if `start`=1 at an edge, go to LOAD with frame=0 and k=0.
- FSM LOAD: each edge registers ROM word k into operand register k and increments k. After k=7 is registered, go to CALC.
- FSM CALC: one edge registers all four outputs from the combinational datapath.
  - If frame < NUM_FRAMES−1: frame++, k=0, go to LOAD.
  - Otherwise: go to IDLE.
- Timing: if `start` is sampled at edge E, outputs for frame n update at edge E+9(n+1). Frame 3 (last) updates at E+36.
- Outputs hold their value between updates and after returning to IDLE.
- `start` outside IDLE is ignored, including when held high during LOAD. A new `start` in IDLE restarts from frame 0.
- Arithmetic: signed 16×16 products give 32-bit results; four-term sums use ≥34-bit accumulators.
  - Re(s1) = h1r·y1r + h1i·y1i + h2r·y2r + h2i·y2i
  - Im(s1) = h1r·y1i − h1i·y1r + h2i·y2r − h2r·y2i
  - Re(s2) = h2r·y1r + h2i·y1i − h1r·y2r − h1i·y2i
  - Im(s2) = h2r·y1i − h2i·y1r − h1i·y2r + h1r·y2i
- Scaling: arithmetic shift right by FRAC (truncation toward −∞), then saturate to [0x8000, 0x7FFF].
- Default ROM contents (hex; h1r h1i h2r h2i y1r y1i y2r y2i):
  - F0: 0800 0000 0400 0400 0800 0800 F800 0000
  - F1: 3FFF 3FFF 0000 0000 3FFF 3FFF 0000 0000
  - F2: all 0000
  - F3: 0800 0000 0400 0400 F800 F800 0800 0000

Decomposition:
- Shared package `xixq_pkg`:
  - Constants DW, FRAC, NUM_FRAMES.
  - Saturation limits.
  - Frame-word index enum (H1R..Y2I).
  - FSM state typedef {IDLE, LOAD, CALC}.
  - Default ROM constant array.
- One natural sub-module `xixq_cmac`: a combinational 4-term signed product sum with per-term sign control, shift by FRAC and saturation. Instantiate it four times.
- FSM, counters and registers live in the top level.

Test Plan:
- Reset: rst=1 for 2 edges -> all outputs 0x0000. Idle with start=0 for 20 cycles -> outputs stay 0.
- Start pulse (high 2 edges) -> at E+9: xI1=0x0400, xQ1=0x0400, xI2=0x1000, xQ2=0x0000. Values hold through E+17.
- Saturation, frame 1 -> at E+18: xI1=0x7FFF, xQ1=0x0000, xI2=0x0000, xQ2=0x0000.
- Zero and negative frames -> at E+27: all 0x0000. At E+36: xI1=0xFC00, xQ1=0xFC00, xI2=0xF000, xQ2=0x0000. Then IDLE, outputs held for 200 cycles.
- start re-asserted during LOAD -> ignored, timing unchanged. start after completion -> full sequence repeats from F0 with identical timing.
- rst asserted at E+20 -> next edge all outputs 0 and FSM IDLE. A following start gives F0 results 9 edges after it is sampled.
